// File: rtl/tla_com_sequencer.sv
`timescale 1ns/1ps
// tla_com_sequencer: Gc_clk125-domain open/close sequencer for the com/cap control bus of the 125->200 MHz crossing.
//   Gc_clk125, Gc_rst_n        : sole clock, asynchronous active-low reset
//   req_open, req_close         : single-cycle host strobes
//   cfg_mode/wdis/cap_plus/com_plus : configuration latched on the open-accept edge
//   err_clr                     : clears the sticky timeout flag
//   Gc_wdis                     : window-select readback from the 200 MHz side (asynchronous)
//   Gc_cap_*, Gc_com_wdis/plus  : quasi-static registered config buses
//   Gc_com_open, Gc_com_close   : single-cycle pulses
//   busy, sess_open, err_tmo    : status
module tla_com_sequencer #(
  parameter int TOP0_0 = 3,
  parameter int LDD0_0 = 32,
  parameter int GAP    = 8,
  parameter int TMO    = 64,
  parameter int CW     = 8
) (
  input  logic              Gc_clk125,
  input  logic              Gc_rst_n,
  input  logic              req_open,
  input  logic              req_close,
  input  logic              cfg_mode,
  input  logic [TOP0_0-1:0] cfg_wdis,
  input  logic [LDD0_0-1:0] cfg_cap_plus,
  input  logic [LDD0_0-1:0] cfg_com_plus,
  input  logic              err_clr,
  input  logic [TOP0_0-1:0] Gc_wdis,
  output logic              Gc_cap_mode,
  output logic [TOP0_0-1:0] Gc_cap_wdis,
  output logic [LDD0_0-1:0] Gc_cap_plus,
  output logic [TOP0_0-1:0] Gc_com_wdis,
  output logic [LDD0_0-1:0] Gc_com_plus,
  output logic              Gc_com_open,
  output logic              Gc_com_close,
  output logic              busy,
  output logic              sess_open,
  output logic              err_tmo
);
  typedef enum logic [2:0] {IDLE, SETTLE, P_OPEN, WAIT_ACK, OPEN, P_CLOSE, GUARD} state_e;
  localparam logic [CW-1:0] GAP_M1 = CW'(GAP - 1);
  localparam logic [CW-1:0] TMO_M1 = CW'(TMO - 1);
  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                ld;
  logic [TOP0_0-1:0]   wdis_m_q, wdis_s_q;
  logic                cap_mode_q;
  logic [TOP0_0-1:0]   wdis_q;
  logic [LDD0_0-1:0]   cap_plus_q, com_plus_q;
  logic                open_q, close_q, busy_q, sess_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_clr ? 1'b0 : err_q;
    ld      = 1'b0;
    case (state_q)
      IDLE: if (req_open) begin
        ld      = 1'b1;
        cnt_d   = GAP_M1;
        state_d = SETTLE;
      end
      SETTLE: begin
        state_d = (cnt_q == '0) ? P_OPEN : SETTLE;
        cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - CW'(1);
      end
      P_OPEN: begin
        state_d = WAIT_ACK;
        cnt_d   = '0;
      end
      WAIT_ACK: begin
        if (req_close) state_d = P_CLOSE;
        else if (wdis_s_q == wdis_q) state_d = OPEN;
        else if (cnt_q == TMO_M1) begin
          err_d   = 1'b1;
          state_d = P_CLOSE;
        end else cnt_d = cnt_q + CW'(1);
      end
      OPEN: state_d = req_close ? P_CLOSE : OPEN;
      P_CLOSE: begin
        cnt_d   = GAP_M1;
        state_d = GUARD;
      end
      GUARD: begin
        state_d = (cnt_q == '0) ? IDLE : GUARD;
        cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  // Status and pulse outputs are decoded from the next state so they leave a flop glitch-free.
  always_ff @(posedge Gc_clk125 or negedge Gc_rst_n) begin
    if (!Gc_rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      wdis_m_q   <= '0;
      wdis_s_q   <= '0;
      cap_mode_q <= 1'b0;
      wdis_q     <= '0;
      cap_plus_q <= '0;
      com_plus_q <= '0;
      open_q     <= 1'b0;
      close_q    <= 1'b0;
      busy_q     <= 1'b0;
      sess_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      wdis_m_q <= Gc_wdis;
      wdis_s_q <= wdis_m_q;
      if (ld) begin
        cap_mode_q <= cfg_mode;
        wdis_q     <= cfg_wdis;
        cap_plus_q <= cfg_cap_plus;
        com_plus_q <= cfg_com_plus;
      end
      open_q  <= state_d == P_OPEN;
      close_q <= state_d == P_CLOSE;
      busy_q  <= !(state_d == IDLE || state_d == OPEN);
      sess_q  <= state_d == OPEN;
    end
  end
  assign Gc_cap_mode  = cap_mode_q;
  assign Gc_cap_wdis  = wdis_q;
  assign Gc_cap_plus  = cap_plus_q;
  assign Gc_com_wdis  = wdis_q;
  assign Gc_com_plus  = com_plus_q;
  assign Gc_com_open  = open_q;
  assign Gc_com_close = close_q;
  assign busy         = busy_q;
  assign sess_open    = sess_q;
  assign err_tmo      = err_q;
endmodule
